sdram_port_arbiter: RTL and testbench

SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

---
 rtl/sdram_port_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: grants the SDRAM controller to refresh, the sensor write
// FIFO, or one of two HDMI read FIFOs, and tracks one frame address per port.
// Ports:
//   CLK, RESET                        clock, synchronous active-high reset
//   REF_REQ / REF_ACK                 refresh request / one-cycle grant pulse
//   WR_LEVEL, RD1_LEVEL, RD2_LEVEL    FIFO fill levels
//   WR_FRAME, RD_FRAME                frame-start pulses (restart addresses)
//   CMD_VALID/TYPE/ADDR/LEN, CMD_ACK  command handshake to the controller
//   CMD_DONE                          burst/refresh completion pulse
//   BUSY                              a command is outstanding
module sdram_port_arbiter #(
    parameter int unsigned WR_LEN   = 64,
    parameter int unsigned RD_LEN   = 32,
    parameter int unsigned MAX_ADDR = 307200,
    parameter int unsigned RD_LOW   = 256,
    parameter int unsigned AW       = 23,
    parameter int unsigned LW       = 10
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          REF_REQ,
    input  logic [LW-1:0] WR_LEVEL,
    input  logic [LW-1:0] RD1_LEVEL,
    input  logic [LW-1:0] RD2_LEVEL,
    input  logic          WR_FRAME,
    input  logic          RD_FRAME,
    input  logic          CMD_ACK,
    input  logic          CMD_DONE,
    output logic          CMD_VALID,
    output logic [1:0]    CMD_TYPE,
    output logic [AW-1:0] CMD_ADDR,
    output logic [7:0]    CMD_LEN,
    output logic          REF_ACK,
    output logic          BUSY
);

    localparam int unsigned AW1 = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [1:0] T_REF = 2'd0;
    localparam logic [1:0] T_WR  = 2'd1;
    localparam logic [1:0] T_RD1 = 2'd2;
    localparam logic [1:0] T_RD2 = 2'd3;

    logic [1:0]    r_state,     w_nxt_state;
    logic          r_cmd_valid, w_nxt_cmd_valid;
    logic [1:0]    r_cmd_type,  w_nxt_cmd_type;
    logic [AW-1:0] r_cmd_addr,  w_nxt_cmd_addr;
    logic [7:0]    r_cmd_len,   w_nxt_cmd_len;
    logic          r_ref_ack,   w_nxt_ref_ack;
    logic          r_busy,      w_nxt_busy;
    logic          r_rr_rd2,    w_nxt_rr_rd2;   // 1: read2 wins a read tie
    logic [AW-1:0] r_wr_addr,   w_nxt_wr_addr;
    logic [AW-1:0] r_rd1_addr,  w_nxt_rd1_addr;
    logic [AW-1:0] r_rd2_addr,  w_nxt_rd2_addr;
    logic          r_wr_pend,   w_nxt_wr_pend;
    logic          r_rd1_pend,  w_nxt_rd1_pend;
    logic          r_rd2_pend,  w_nxt_rd2_pend;

    logic w_req_wr, w_req_rd1, w_req_rd2;
    logic w_done_wr, w_done_rd1, w_done_rd2;
    logic w_act_wr, w_act_rd1, w_act_rd2;

    // Next burst address; a burst that would reach MAX_ADDR restarts at 0.
    function automatic logic [AW-1:0] f_advance(input logic [AW-1:0] a, input logic [AW1-1:0] len);
        logic [AW1-1:0] s;
        s = {1'b0, a} + len;
        return (s >= AW1'(MAX_ADDR)) ? '0 : s[AW-1:0];
    endfunction

    assign w_req_wr  = (WR_LEVEL >= LW'(WR_LEN));
    assign w_req_rd1 = (RD1_LEVEL < LW'(RD_LOW));
    assign w_req_rd2 = (RD2_LEVEL < LW'(RD_LOW));

    // A port is active while its command sits in ISSUE or WAIT_DONE.
    assign w_act_wr   = (r_state != S_IDLE) && (r_cmd_type == T_WR);
    assign w_act_rd1  = (r_state != S_IDLE) && (r_cmd_type == T_RD1);
    assign w_act_rd2  = (r_state != S_IDLE) && (r_cmd_type == T_RD2);
    assign w_done_wr  = (r_state == S_WAIT) && CMD_DONE && (r_cmd_type == T_WR);
    assign w_done_rd1 = (r_state == S_WAIT) && CMD_DONE && (r_cmd_type == T_RD1);
    assign w_done_rd2 = (r_state == S_WAIT) && CMD_DONE && (r_cmd_type == T_RD2);

    // Next-state, command and counter logic.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_cmd_valid = r_cmd_valid;
        w_nxt_cmd_type  = r_cmd_type;
        w_nxt_cmd_addr  = r_cmd_addr;
        w_nxt_cmd_len   = r_cmd_len;
        w_nxt_ref_ack   = 1'b0;
        w_nxt_rr_rd2    = r_rr_rd2;
        w_nxt_wr_addr   = r_wr_addr;
        w_nxt_rd1_addr  = r_rd1_addr;
        w_nxt_rd2_addr  = r_rd2_addr;
        w_nxt_wr_pend   = r_wr_pend;
        w_nxt_rd1_pend  = r_rd1_pend;
        w_nxt_rd2_pend  = r_rd2_pend;

        case (r_state)
            S_IDLE: begin
                // A frame pulse in the grant cycle makes the burst start at 0.
                if (REF_REQ) begin
                    w_nxt_cmd_type = T_REF;
                    w_nxt_cmd_addr = '0;
                    w_nxt_cmd_len  = 8'd0;
                    w_nxt_state    = S_ISSUE;
                end else if (w_req_wr) begin
                    w_nxt_cmd_type = T_WR;
                    w_nxt_cmd_addr = WR_FRAME ? '0 : r_wr_addr;
                    w_nxt_cmd_len  = 8'(WR_LEN);
                    w_nxt_state    = S_ISSUE;
                end else if (w_req_rd1 && (!w_req_rd2 || !r_rr_rd2)) begin
                    w_nxt_cmd_type = T_RD1;
                    w_nxt_cmd_addr = RD_FRAME ? '0 : r_rd1_addr;
                    w_nxt_cmd_len  = 8'(RD_LEN);
                    w_nxt_rr_rd2   = 1'b1;
                    w_nxt_state    = S_ISSUE;
                end else if (w_req_rd2) begin
                    w_nxt_cmd_type = T_RD2;
                    w_nxt_cmd_addr = RD_FRAME ? '0 : r_rd2_addr;
                    w_nxt_cmd_len  = 8'(RD_LEN);
                    w_nxt_rr_rd2   = 1'b0;
                    w_nxt_state    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // First ISSUE cycle raises CMD_VALID; ACK only counts once presented.
                if (!r_cmd_valid) begin
                    w_nxt_cmd_valid = 1'b1;
                end else if (CMD_ACK) begin
                    w_nxt_cmd_valid = 1'b0;
                    w_nxt_ref_ack   = (r_cmd_type == T_REF);
                    w_nxt_state     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (CMD_DONE) begin
                    w_nxt_state = S_IDLE;
                end
            end
            default: begin
                w_nxt_state     = S_IDLE;
                w_nxt_cmd_valid = 1'b0;
            end
        endcase

        w_nxt_busy = (w_nxt_state != S_IDLE);

        // Frame restart: immediate when idle, deferred to completion when active.
        if (w_done_wr) begin
            w_nxt_wr_addr = (r_wr_pend || WR_FRAME) ? '0 : f_advance(r_wr_addr, AW1'(WR_LEN));
            w_nxt_wr_pend = 1'b0;
        end else if (WR_FRAME) begin
            if (w_act_wr) w_nxt_wr_pend = 1'b1;
            else          w_nxt_wr_addr = '0;
        end

        if (w_done_rd1) begin
            w_nxt_rd1_addr = (r_rd1_pend || RD_FRAME) ? '0 : f_advance(r_rd1_addr, AW1'(RD_LEN));
            w_nxt_rd1_pend = 1'b0;
        end else if (RD_FRAME) begin
            if (w_act_rd1) w_nxt_rd1_pend = 1'b1;
            else           w_nxt_rd1_addr = '0;
        end

        if (w_done_rd2) begin
            w_nxt_rd2_addr = (r_rd2_pend || RD_FRAME) ? '0 : f_advance(r_rd2_addr, AW1'(RD_LEN));
            w_nxt_rd2_pend = 1'b0;
        end else if (RD_FRAME) begin
            if (w_act_rd2) w_nxt_rd2_pend = 1'b1;
            else           w_nxt_rd2_addr = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_cmd_valid <= 1'b0;
            r_cmd_type  <= T_REF;
            r_cmd_addr  <= '0;
            r_cmd_len   <= 8'd0;
            r_ref_ack   <= 1'b0;
            r_busy      <= 1'b0;
            r_rr_rd2    <= 1'b0;
            r_wr_addr   <= '0;
            r_rd1_addr  <= '0;
            r_rd2_addr  <= '0;
            r_wr_pend   <= 1'b0;
            r_rd1_pend  <= 1'b0;
            r_rd2_pend  <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_cmd_valid <= w_nxt_cmd_valid;
            r_cmd_type  <= w_nxt_cmd_type;
            r_cmd_addr  <= w_nxt_cmd_addr;
            r_cmd_len   <= w_nxt_cmd_len;
            r_ref_ack   <= w_nxt_ref_ack;
            r_busy      <= w_nxt_busy;
            r_rr_rd2    <= w_nxt_rr_rd2;
            r_wr_addr   <= w_nxt_wr_addr;
            r_rd1_addr  <= w_nxt_rd1_addr;
            r_rd2_addr  <= w_nxt_rd2_addr;
            r_wr_pend   <= w_nxt_wr_pend;
            r_rd1_pend  <= w_nxt_rd1_pend;
            r_rd2_pend  <= w_nxt_rd2_pend;
        end
    end

    assign CMD_VALID = r_cmd_valid;
    assign CMD_TYPE  = r_cmd_type;
    assign CMD_ADDR  = r_cmd_addr;
    assign CMD_LEN   = r_cmd_len;
    assign REF_ACK   = r_ref_ack;
    assign BUSY      = r_busy;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed testbench for sdram_port_arbiter: write sequencing, priority and
// round-robin, address wrap, frame restarts, reset abort and handshake hold.
module tb_sdram_port_arbiter;

    localparam int AW = 23;
    localparam int LW = 10;

    logic          CLK;
    logic          RESET;
    logic          REF_REQ;
    logic [LW-1:0] WR_LEVEL;
    logic [LW-1:0] RD1_LEVEL;
    logic [LW-1:0] RD2_LEVEL;
    logic          WR_FRAME;
    logic          RD_FRAME;
    logic          CMD_ACK;
    logic          CMD_DONE;
    logic          CMD_VALID;
    logic [1:0]    CMD_TYPE;
    logic [AW-1:0] CMD_ADDR;
    logic [7:0]    CMD_LEN;
    logic          REF_ACK;
    logic          BUSY;

    int n_checks = 0;
    int n_errors = 0;
    int ref_cnt  = 0;

    sdram_port_arbiter dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REF_REQ   (REF_REQ),
        .WR_LEVEL  (WR_LEVEL),
        .RD1_LEVEL (RD1_LEVEL),
        .RD2_LEVEL (RD2_LEVEL),
        .WR_FRAME  (WR_FRAME),
        .RD_FRAME  (RD_FRAME),
        .CMD_ACK   (CMD_ACK),
        .CMD_DONE  (CMD_DONE),
        .CMD_VALID (CMD_VALID),
        .CMD_TYPE  (CMD_TYPE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_LEN   (CMD_LEN),
        .REF_ACK   (REF_ACK),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (REF_ACK) ref_cnt <= ref_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        REF_REQ   = 1'b0;
        WR_LEVEL  = '0;
        RD1_LEVEL = 10'd1023;
        RD2_LEVEL = 10'd1023;
        WR_FRAME  = 1'b0;
        RD_FRAME  = 1'b0;
        CMD_ACK   = 1'b0;
        CMD_DONE  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    // Wait (bounded) for CMD_VALID, then check the presented command.
    task automatic wait_cmd(input string tag, input logic [1:0] et, input logic [AW-1:0] ea, input logic [7:0] el);
        int n;
        n = 0;
        while (!CMD_VALID && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(CMD_VALID), 1);
        check({tag, "_type"},  32'(CMD_TYPE), 32'(et));
        check({tag, "_addr"},  32'(CMD_ADDR), 32'(ea));
        check({tag, "_len"},   32'(CMD_LEN),  32'(el));
    endtask

    // Serve one command: hold ACK back ack_dly cycles (checking stability),
    // ACK, wait done_dly cycles, then DONE (optionally with a WR_FRAME pulse).
    task automatic serve(input string tag, input logic [1:0] et, input logic [AW-1:0] ea,
                         input logic [7:0] el, input int ack_dly, input int done_dly,
                         input logic wr_frame_at_done);
        wait_cmd(tag, et, ea, el);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check({tag, "_hold_valid"}, 32'(CMD_VALID), 1);
            check({tag, "_hold_type"},  32'(CMD_TYPE), 32'(et));
            check({tag, "_hold_addr"},  32'(CMD_ADDR), 32'(ea));
            check({tag, "_hold_len"},   32'(CMD_LEN),  32'(el));
        end
        CMD_ACK = 1'b1;
        tick();
        CMD_ACK = 1'b0;
        check({tag, "_ref_ack"}, 32'(REF_ACK), 32'(et == 2'd0));
        check({tag, "_drop"},    32'(CMD_VALID), 0);
        check({tag, "_busy"},    32'(BUSY), 1);
        if (REF_ACK) REF_REQ = 1'b0;
        repeat (done_dly) tick();
        CMD_DONE = 1'b1;
        WR_FRAME = wr_frame_at_done;
        tick();
        CMD_DONE = 1'b0;
        WR_FRAME = 1'b0;
        check({tag, "_idle"}, 32'(BUSY), 0);
    endtask

    initial begin
        int n;
        int snap;
        RESET = 1'b1;
        idle_inputs();

        // Reset state
        do_reset();
        check("rst_valid", 32'(CMD_VALID), 0);
        check("rst_busy",  32'(BUSY), 0);
        check("rst_type",  32'(CMD_TYPE), 0);
        check("rst_addr",  32'(CMD_ADDR), 0);
        check("rst_len",   32'(CMD_LEN), 0);
        check("rst_refack", 32'(REF_ACK), 0);

        // Write only: two-cycle latency, addresses 0/64/128, ACK held 10 cycles on the third
        WR_LEVEL = 10'd64;
        tick();
        check("lat1_busy",  32'(BUSY), 1);
        check("lat1_valid", 32'(CMD_VALID), 0);
        tick();
        check("lat2_valid", 32'(CMD_VALID), 1);
        serve("wr0", 2'd1, 0,   8'd64, 3, 3, 1'b0);
        serve("wr1", 2'd1, 64,  8'd64, 3, 3, 1'b0);
        serve("wr2", 2'd1, 128, 8'd64, 10, 3, 1'b0);
        WR_LEVEL = 10'd63;
        repeat (3) tick();
        check("wr63_noreq", 32'(BUSY), 0);
        // Frame pulse while idle clears the write address next cycle
        WR_FRAME = 1'b1;
        tick();
        WR_FRAME = 1'b0;
        check("wrframe_idle", 32'(dut.r_wr_addr), 0);
        WR_LEVEL = 10'd64;
        serve("wr_f0", 2'd1, 0,  8'd64, 0, 0, 1'b0);
        // Frame pulse coincident with completion: clear beats advance
        serve("wr_f1", 2'd1, 64, 8'd64, 0, 0, 1'b1);
        serve("wr_f2", 2'd1, 0,  8'd64, 0, 0, 1'b0);
        WR_LEVEL = '0;

        // Priority and round-robin
        do_reset();
        snap = ref_cnt;
        REF_REQ   = 1'b1;
        WR_LEVEL  = 10'd100;
        RD1_LEVEL = '0;
        RD2_LEVEL = '0;
        serve("p_ref", 2'd0, 0, 8'd0,  2, 2, 1'b0);
        serve("p_wr",  2'd1, 0, 8'd64, 1, 1, 1'b0);
        WR_LEVEL = '0;
        serve("p_rd1", 2'd2, 0,  8'd32, 1, 1, 1'b0);
        serve("p_rd2", 2'd3, 0,  8'd32, 1, 1, 1'b0);
        serve("p_rd1b", 2'd2, 32, 8'd32, 1, 1, 1'b0);
        RD1_LEVEL = 10'd1023;
        RD2_LEVEL = 10'd1023;
        repeat (2) tick();
        check("p_refack_count", 32'(ref_cnt - snap), 1);

        // Read1 wrap at the end of the frame (ACK/DONE held high)
        do_reset();
        RD1_LEVEL = '0;
        CMD_ACK   = 1'b1;
        CMD_DONE  = 1'b1;
        n = 0;
        for (int c = 0; c < 40000 && n < 9601; c++) begin
            tick();
            if (CMD_VALID) begin
                if (n == 1)    check("wrap_addr1", 32'(CMD_ADDR), 32);
                if (n == 9599) check("wrap_last",  32'(CMD_ADDR), 307168);
                if (n == 9600) begin
                    check("wrap_zero", 32'(CMD_ADDR), 0);
                    check("wrap_type", 32'(CMD_TYPE), 2);
                end
                n++;
            end
        end
        check("wrap_count", 32'(n), 9601);
        idle_inputs();

        // RD_FRAME during read2 WAIT_DONE
        do_reset();
        RD1_LEVEL = '0;
        RD2_LEVEL = '0;
        for (int i = 0; i < 6; i++) begin
            serve("rr", (i % 2 == 0) ? 2'd2 : 2'd3, AW'((i / 2) * 32), 8'd32, 0, 0, 1'b0);
        end
        RD1_LEVEL = 10'd1023;
        for (int j = 0; j < 7; j++) begin
            serve("rd2_only", 2'd3, AW'((3 + j) * 32), 8'd32, 0, 0, 1'b0);
        end
        wait_cmd("rd2_320", 2'd3, 320, 8'd32);
        CMD_ACK = 1'b1;
        tick();
        CMD_ACK = 1'b0;
        RD_FRAME = 1'b1;
        tick();
        RD_FRAME = 1'b0;
        check("rdf_rd1_clr",  32'(dut.r_rd1_addr), 0);
        check("rdf_rd2_hold", 32'(dut.r_rd2_addr), 320);
        check("rdf_busy",     32'(BUSY), 1);
        CMD_DONE = 1'b1;
        tick();
        CMD_DONE = 1'b0;
        check("rdf_rd2_clr", 32'(dut.r_rd2_addr), 0);
        RD1_LEVEL = '0;
        serve("rdf_rd1", 2'd2, 0, 8'd32, 0, 0, 1'b0);
        serve("rdf_rd2", 2'd3, 0, 8'd32, 0, 0, 1'b0);
        RD1_LEVEL = 10'd1023;
        RD2_LEVEL = 10'd1023;

        // Reset during WAIT_DONE, then stray DONE/ACK
        do_reset();
        WR_LEVEL = 10'd64;
        for (int i = 0; i < 10; i++) begin
            serve("w10", 2'd1, AW'(i * 64), 8'd64, 0, 0, 1'b0);
        end
        wait_cmd("w640", 2'd1, 640, 8'd64);
        CMD_ACK = 1'b1;
        tick();
        CMD_ACK = 1'b0;
        RESET    = 1'b1;
        WR_LEVEL = '0;
        tick();
        RESET = 1'b0;
        check("rstw_valid", 32'(CMD_VALID), 0);
        check("rstw_busy",  32'(BUSY), 0);
        check("rstw_wr",    32'(dut.r_wr_addr), 0);
        CMD_DONE = 1'b1;
        tick();
        CMD_DONE = 1'b0;
        check("stray_done_busy", 32'(BUSY), 0);
        check("stray_done_wr",   32'(dut.r_wr_addr), 0);
        CMD_ACK = 1'b1;
        tick();
        CMD_ACK = 1'b0;
        check("stray_ack_valid", 32'(CMD_VALID), 0);
        check("stray_ack_busy",  32'(BUSY), 0);
        WR_LEVEL = 10'd64;
        serve("post_rst_wr", 2'd1, 0, 8'd64, 0, 0, 1'b0);
        WR_LEVEL = '0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
